// File: rtl/genetic_pkg.sv
// Shared chromosome geometry for the genetic circuit: derived widths, field offsets, loader states.
// Widths and offsets are functions of the block parameters so loader, decoder and bench agree bit-exactly.
package genetic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } loader_state_t;

    function automatic int f_total(input int row, input int col);
        return row * col;
    endfunction

    function automatic int f_bits_mat(input int row, input int col);
        return 16 * f_total(row, col);
    endfunction

    function automatic int f_bits_mux(input int row, input int col, input int bits_sel);
        return 4 * bits_sel * f_total(row, col);
    endfunction

    function automatic int f_chrom_w(input int row, input int col, input int out,
                                     input int bits_sel, input int bits_elem);
        return f_bits_mat(row, col) + bits_elem * out + f_bits_mux(row, col, bits_sel);
    endfunction

    function automatic int f_nwords(input int chrom_w, input int w);
        return (chrom_w + w - 1) / w;
    endfunction

    // Truth table of element (i,j), 16 bits wide.
    function automatic int tt_off(input int i, input int j, input int col);
        return 16 * (col * i + j);
    endfunction

    // Output selector k, bits_elem wide.
    function automatic int outsel_off(input int k, input int bits_mat, input int bits_elem);
        return bits_mat + bits_elem * k;
    endfunction

    // Input selector b of element a, bits_sel wide.
    function automatic int insel_off(input int a, input int b, input int bits_mat,
                                     input int out, input int bits_elem, input int bits_sel);
        return bits_mat + out * bits_elem + 4 * bits_sel * a + bits_sel * b;
    endfunction

endpackage

// File: rtl/chrom_serial_loader.sv
// Assembles a chromosome from a word stream (LSB word first) and commits it atomically.
// Commit lands 2 clocks after the final word is accepted; s_ready drops only in the COMMIT cycle.
module chrom_serial_loader
    import genetic_pkg::*;
#(
    parameter int ROW       = 2,
    parameter int COL       = 2,
    parameter int IN        = 4,
    parameter int OUT       = 2,
    parameter int BITS_SEL  = 3,
    parameter int BITS_ELEM = 3,
    parameter int W         = 16
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [W-1:0]                                       s_data,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    input  logic                                               s_last,
    input  logic                                               abort,
    output logic [f_chrom_w(ROW, COL, OUT, BITS_SEL, BITS_ELEM)-1:0] chrom,
    output logic                                               chrom_valid,
    output logic                                               commit,
    output logic                                               frame_err,
    output logic                                               busy
);

    localparam int CHROM_W = f_chrom_w(ROW, COL, OUT, BITS_SEL, BITS_ELEM);
    localparam int NWORDS  = f_nwords(CHROM_W, W);
    localparam int IDXW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    // A selector must be able to address every primary input.
    if (IN > (1 << BITS_SEL)) begin : g_in_chk
        $error("BITS_SEL too narrow for IN primary inputs");
    end

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_nxt;
    logic [CHROM_W-1:0] shadow;

    logic accept;
    logic at_last;
    logic wr_en;
    logic err_set;
    logic commit_set;

    assign accept  = s_valid && s_ready;
    assign at_last = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; IDLE shares LOAD's rules since idx is always 0 there
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    if (s_last && !at_last) begin
                        state_nxt = IDLE;
                    end else if (at_last) begin
                        state_nxt = s_last ? COMMIT : DRAIN;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (abort || (accept && s_last)) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        s_ready    = !rst && (state != COMMIT);
        busy       = (state != IDLE);
        wr_en      = accept && !abort && ((state == IDLE) || (state == LOAD));
        err_set    = accept && !abort && s_last &&
                     ((((state == IDLE) || (state == LOAD)) && !at_last) || (state == DRAIN));
        commit_set = (state == COMMIT);
        idx_nxt    = '0;
        if (state_nxt == LOAD) begin
            idx_nxt = wr_en ? (idx + 1'b1) : idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            chrom       <= '0;
            chrom_valid <= 1'b0;
            commit      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            commit    <= commit_set;
            frame_err <= err_set;
            if (commit_set) begin
                chrom       <= shadow;
                chrom_valid <= 1'b1;
            end
        end
    end

    // Shadow is deliberately not reset; bits beyond CHROM_W in the last word are dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int p = 0; p < CHROM_W; p++) begin
                if (idx == IDXW'(p / W)) begin
                    shadow[p] <= s_data[p % W];
                end
            end
        end
    end

endmodule
